// File: rtl/lcb_pkg.sv
// Shared LCB framing definitions: state encoding, default sizing and the byte checksum.
package lcb_pkg;

  localparam int unsigned PKT_LEN_DEF = 4;
  localparam int unsigned GAP_CYC_DEF = 400;
  localparam int unsigned LCB_ADDR_W  = 5;
  localparam int unsigned CNT_W_DEF   = 16;
  localparam int unsigned ST_W        = 2;

  localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] ST_RECV  = 2'd1;
  localparam logic [ST_W-1:0] ST_CHECK = 2'd2;
  localparam logic [ST_W-1:0] ST_TAIL  = 2'd3;

  // Modulo-256 running checksum step.
  function automatic logic [7:0] lcb_sum8(input logic [7:0] acc, input logic [7:0] b);
    return 8'(acc + b);
  endfunction

endpackage

// File: rtl/lcb_rx_framer_if.sv
// Byte-receive and buffer-write bundle between uartRx, the framer and ramUART.
interface lcb_rx_framer_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 16
);
  logic              rstTx;
  logic              strob;
  logic [7:0]        iData;
  logic [ADDR_W-1:0] wrAdr;
  logic [7:0]        wrData;
  logic              WE;
  logic              full;
  logic              errSum;
  logic              errLen;
  logic              errOvr;
  logic              busy;
  logic [CNT_W-1:0]  pktCnt;

  // master: byte source side; slave: the framer
  modport master (
    output rstTx, strob, iData,
    input  wrAdr, wrData, WE, full, errSum, errLen, errOvr, busy, pktCnt
  );

  modport slave (
    input  rstTx, strob, iData,
    output wrAdr, wrData, WE, full, errSum, errLen, errOvr, busy, pktCnt
  );
endinterface

// File: rtl/lcb_gap_timer.sv
// Saturating idle-cycle counter; timeout flags the cycle in which the count reaches LIMIT.
module lcb_gap_timer #(
  parameter int unsigned LIMIT = 400
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout
);
  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && (count != CW'(LIMIT))) begin
      count <= count + CW'(1);
    end
  end

  // High while the next increment lands on LIMIT, so the consumer acts on that same edge.
  assign timeout = en && !clr && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/lcb_rx_framer.sv
// Groups uartRx byte strobes into fixed-length LCB answer packets, writes them to the
// answer buffer, verifies the trailing checksum and flags length/checksum/overrun errors.
module lcb_rx_framer
  import lcb_pkg::*;
#(
  parameter int unsigned PKT_LEN = PKT_LEN_DEF,
  parameter int unsigned ADDR_W  = LCB_ADDR_W,
  parameter int unsigned GAP_CYC = GAP_CYC_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input logic            clk,
  input logic            rst,
  lcb_rx_framer_if.slave bus
);
  localparam int unsigned     BCW      = $clog2(PKT_LEN + 1);
  localparam logic [BCW-1:0]  LAST_IDX = BCW'(PKT_LEN - 1);

  logic [ST_W-1:0]   state, state_nxt;
  logic [BCW-1:0]    byte_cnt, byte_cnt_nxt;
  logic [7:0]        sum, sum_nxt;
  logic              gap_clr, gap_en, timeout;

  logic              we_nxt, full_nxt, err_sum_nxt, err_len_nxt, err_ovr_nxt, busy_nxt;
  logic [ADDR_W-1:0] adr_nxt;
  logic [7:0]        data_nxt;
  logic [CNT_W-1:0]  cnt_nxt;

  // Any accepted or rejected byte restarts the idle window.
  assign gap_clr = bus.rstTx || bus.strob || (state == ST_IDLE);
  assign gap_en  = (state != ST_IDLE);

  lcb_gap_timer #(
    .LIMIT (GAP_CYC)
  ) u_gap_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (gap_clr),
    .en      (gap_en),
    .timeout (timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      byte_cnt   <= '0;
      sum        <= '0;
      bus.WE     <= 1'b0;
      bus.wrAdr  <= '0;
      bus.wrData <= '0;
      bus.full   <= 1'b0;
      bus.errSum <= 1'b0;
      bus.errLen <= 1'b0;
      bus.errOvr <= 1'b0;
      bus.busy   <= 1'b0;
      bus.pktCnt <= '0;
    end else begin
      state      <= state_nxt;
      byte_cnt   <= byte_cnt_nxt;
      sum        <= sum_nxt;
      bus.WE     <= we_nxt;
      bus.wrAdr  <= adr_nxt;
      bus.wrData <= data_nxt;
      bus.full   <= full_nxt;
      bus.errSum <= err_sum_nxt;
      bus.errLen <= err_len_nxt;
      bus.errOvr <= err_ovr_nxt;
      bus.busy   <= busy_nxt;
      bus.pktCnt <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    byte_cnt_nxt = byte_cnt;
    sum_nxt      = sum;
    we_nxt       = 1'b0;
    adr_nxt      = bus.wrAdr;
    data_nxt     = bus.wrData;
    full_nxt     = 1'b0;
    err_sum_nxt  = 1'b0;
    err_len_nxt  = 1'b0;
    err_ovr_nxt  = 1'b0;
    cnt_nxt      = bus.pktCnt;

    if (bus.rstTx) begin
      // Transmitter re-arm: drop any partial packet, including a coincident byte.
      state_nxt    = ST_IDLE;
      byte_cnt_nxt = '0;
      sum_nxt      = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.strob) begin
            we_nxt       = 1'b1;
            adr_nxt      = '0;
            data_nxt     = bus.iData;
            byte_cnt_nxt = BCW'(1);
            sum_nxt      = bus.iData;
            state_nxt    = ST_RECV;
          end
        end
        ST_RECV: begin
          if (bus.strob) begin
            we_nxt       = 1'b1;
            adr_nxt      = ADDR_W'(byte_cnt);
            data_nxt     = bus.iData;
            byte_cnt_nxt = byte_cnt + BCW'(1);
            if (byte_cnt == LAST_IDX) begin
              state_nxt = ST_CHECK;
            end else begin
              sum_nxt = lcb_sum8(sum, bus.iData);
            end
          end else if (timeout) begin
            err_len_nxt  = 1'b1;
            byte_cnt_nxt = '0;
            sum_nxt      = '0;
            state_nxt    = ST_IDLE;
          end
        end
        ST_CHECK: begin
          // wrData still holds the checksum byte written on the previous cycle.
          if (sum == bus.wrData) begin
            full_nxt = 1'b1;
            cnt_nxt  = bus.pktCnt + CNT_W'(1);
          end else begin
            err_sum_nxt = 1'b1;
          end
          state_nxt = ST_TAIL;
        end
        ST_TAIL: begin
          if (bus.strob) begin
            err_ovr_nxt = 1'b1;
          end else if (timeout) begin
            byte_cnt_nxt = '0;
            sum_nxt      = '0;
            state_nxt    = ST_IDLE;
          end
        end
        default: begin
          state_nxt    = ST_IDLE;
          byte_cnt_nxt = '0;
          sum_nxt      = '0;
        end
      endcase
    end

    busy_nxt = (state_nxt != ST_IDLE);
  end

endmodule

// File: tb/tb_lcb_rx_framer.sv
// Randomised self-checking bench for lcb_rx_framer; packet outcomes come from a plain
// arithmetic model of the framing rules (byte sums, packet lengths, gap windows).
`timescale 1ns/1ps
module tb_lcb_rx_framer;
  localparam int unsigned PKT_LEN = 4;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned GAP_CYC = 400;
  localparam int unsigned CNT_W   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int exp_cnt = 0, exp_full = 0, exp_sum = 0, exp_len = 0, exp_ovr = 0;
  int n_full = 0, n_sum = 0, n_len = 0, n_ovr = 0;

  lcb_rx_framer_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  lcb_rx_framer #(
    .PKT_LEN (PKT_LEN),
    .ADDR_W  (ADDR_W),
    .GAP_CYC (GAP_CYC),
    .CNT_W   (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Pulse tallies and output exclusivity, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      n_full += int'(bus.full);
      n_sum  += int'(bus.errSum);
      n_len  += int'(bus.errLen);
      n_ovr  += int'(bus.errOvr);
      checks++;
      if ((int'(bus.full) + int'(bus.errSum) + int'(bus.errLen) + int'(bus.errOvr)) > 1 ||
          (bus.WE && bus.full)) begin
        errors++;
        $display("FAIL exclusivity @%0t: full=%b errSum=%b errLen=%b errOvr=%b WE=%b, required at most one flag and no WE with full",
                 $time, bus.full, bus.errSum, bus.errLen, bus.errOvr, bus.WE);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Drive one byte at the current negedge; checks the write (or overrun) one cycle later.
  task automatic send_byte(input logic [7:0] b, input int idx, input bit is_extra);
    bus.strob = 1'b1;
    bus.iData = b;
    @(negedge clk);
    bus.strob = 1'b0;
    bus.iData = 8'($urandom);
    checks++;
    if (!is_extra) begin
      if (bus.WE !== 1'b1 || bus.wrAdr !== ADDR_W'(idx) || bus.wrData !== b) begin
        errors++;
        $display("FAIL write byte%0d: WE=%b wrAdr=%0d wrData=%h, required WE=1 wrAdr=%0d wrData=%h",
                 idx, bus.WE, bus.wrAdr, bus.wrData, idx, b);
      end
    end else if (bus.WE !== 1'b0 || bus.errOvr !== 1'b1) begin
      errors++;
      $display("FAIL overrun byte%0d: WE=%b errOvr=%b, required WE=0 errOvr=1", idx, bus.WE, bus.errOvr);
    end
  endtask

  // Sends a byte sequence and checks checksum verdict, counter and gap-ended return to idle.
  task automatic send_pkt(input logic [7:0] pkt[$], input int sp, input int xsp);
    int  n = pkt.size();
    int  k = 0;
    int  s = 0;
    bit  short_p = (n < int'(PKT_LEN));
    bit  good = 1'b0;
    for (int i = 0; i < n && i < int'(PKT_LEN) - 1; i++) s += int'(pkt[i]);
    if (!short_p) good = ((s % 256) == int'(pkt[PKT_LEN-1]));
    repeat (5) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        while (k < ((i >= int'(PKT_LEN)) ? xsp : sp) - 1) begin
          @(negedge clk);
          k++;
        end
      end
      send_byte(pkt[i], i, i >= int'(PKT_LEN));
      k = 0;
      if (i >= int'(PKT_LEN)) exp_ovr++;
      if (i == int'(PKT_LEN) - 1) begin
        @(negedge clk);
        k = 1;
        if (good) begin
          exp_cnt++;
          exp_full++;
        end else begin
          exp_sum++;
        end
        checks++;
        if (bus.full !== good || bus.errSum !== !good || bus.WE !== 1'b0 ||
            bus.pktCnt !== CNT_W'(exp_cnt)) begin
          errors++;
          $display("FAIL verdict: full=%b errSum=%b WE=%b pktCnt=%0d, required full=%b errSum=%b WE=0 pktCnt=%0d",
                   bus.full, bus.errSum, bus.WE, bus.pktCnt, good, !good, CNT_W'(exp_cnt));
        end
      end
    end
    while (k < int'(GAP_CYC) - 1) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (bus.busy !== 1'b1 || bus.errLen !== 1'b0) begin
      errors++;
      $display("FAIL gap_early: busy=%b errLen=%b one cycle before gap end, required busy=1 errLen=0",
               bus.busy, bus.errLen);
    end
    @(negedge clk);
    if (short_p) exp_len++;
    checks++;
    if (bus.busy !== 1'b0 || bus.errLen !== short_p) begin
      errors++;
      $display("FAIL gap_end: busy=%b errLen=%b at gap end, required busy=0 errLen=%b",
               bus.busy, bus.errLen, short_p);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.strob = 1'b0;
    bus.rstTx = 1'b0;
    bus.iData = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.WE, bus.wrAdr, bus.wrData, bus.full, bus.errSum, bus.errLen, bus.errOvr, bus.busy, bus.pktCnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: WE=%b wrAdr=%0d wrData=%h flags=%b%b%b%b busy=%b pktCnt=%0d, required all 0",
               bus.WE, bus.wrAdr, bus.wrData, bus.full, bus.errSum, bus.errLen, bus.errOvr, bus.busy, bus.pktCnt);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.WE !== 1'b0 || bus.pktCnt !== '0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b WE=%b pktCnt=%0d, required 0 0 0", bus.busy, bus.WE, bus.pktCnt);
    end
  endtask

  task automatic test_good_packet();
    logic [7:0] p[$];
    p = '{8'h10, 8'h20, 8'h30, 8'h60};
    send_pkt(p, 170, 170);
    @(negedge clk);
    checks++;
    if (n_full !== exp_full || n_sum !== exp_sum || n_len !== exp_len || n_ovr !== exp_ovr) begin
      errors++;
      $display("FAIL good_totals: full/errSum/errLen/errOvr=%0d/%0d/%0d/%0d, required %0d/%0d/%0d/%0d",
               n_full, n_sum, n_len, n_ovr, exp_full, exp_sum, exp_len, exp_ovr);
    end
  endtask

  task automatic test_bad_checksum();
    logic [7:0] p[$];
    p = '{8'h10, 8'h20, 8'h30, 8'h61};
    send_pkt(p, 170, 170);
    @(negedge clk);
    checks++;
    if (n_full !== exp_full || n_sum !== exp_sum || n_len !== exp_len || n_ovr !== exp_ovr) begin
      errors++;
      $display("FAIL badsum_totals: full/errSum/errLen/errOvr=%0d/%0d/%0d/%0d, required %0d/%0d/%0d/%0d",
               n_full, n_sum, n_len, n_ovr, exp_full, exp_sum, exp_len, exp_ovr);
    end
  endtask

  task automatic test_short_packet();
    logic [7:0] p[$];
    p = '{8'h01, 8'h02};
    send_pkt(p, 170, 170);
    p = '{8'hAA, 8'h00, 8'h00, 8'hAA};
    send_pkt(p, 170, 170);
    @(negedge clk);
    checks++;
    if (n_full !== exp_full || n_sum !== exp_sum || n_len !== exp_len || n_ovr !== exp_ovr) begin
      errors++;
      $display("FAIL short_totals: full/errSum/errLen/errOvr=%0d/%0d/%0d/%0d, required %0d/%0d/%0d/%0d",
               n_full, n_sum, n_len, n_ovr, exp_full, exp_sum, exp_len, exp_ovr);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] p[$];
    p = '{8'h10, 8'h20, 8'h30, 8'h60, 8'h55};
    send_pkt(p, 170, 100);
    @(negedge clk);
    checks++;
    if (n_full !== exp_full || n_sum !== exp_sum || n_len !== exp_len || n_ovr !== exp_ovr) begin
      errors++;
      $display("FAIL overrun_totals: full/errSum/errLen/errOvr=%0d/%0d/%0d/%0d, required %0d/%0d/%0d/%0d",
               n_full, n_sum, n_len, n_ovr, exp_full, exp_sum, exp_len, exp_ovr);
    end
  endtask

  task automatic test_rsttx();
    logic [7:0] p[$];
    repeat (5) @(negedge clk);
    send_byte(8'h11, 0, 1'b0);
    repeat (169) @(negedge clk);
    send_byte(8'h22, 1, 1'b0);
    repeat (169) @(negedge clk);
    bus.rstTx = 1'b1;
    bus.strob = 1'b1;
    bus.iData = 8'h77;
    @(negedge clk);
    bus.rstTx = 1'b0;
    bus.strob = 1'b0;
    checks++;
    if (bus.WE !== 1'b0 || bus.busy !== 1'b0 || bus.pktCnt !== CNT_W'(exp_cnt)) begin
      errors++;
      $display("FAIL rsttx_drop: WE=%b busy=%b pktCnt=%0d, required WE=0 busy=0 pktCnt=%0d",
               bus.WE, bus.busy, bus.pktCnt, CNT_W'(exp_cnt));
    end
    p = '{8'h01, 8'h01, 8'h01, 8'h03};
    send_pkt(p, 170, 170);
    @(negedge clk);
    checks++;
    if (n_full !== exp_full || n_sum !== exp_sum || n_len !== exp_len || n_ovr !== exp_ovr) begin
      errors++;
      $display("FAIL rsttx_totals: full/errSum/errLen/errOvr=%0d/%0d/%0d/%0d, required %0d/%0d/%0d/%0d",
               n_full, n_sum, n_len, n_ovr, exp_full, exp_sum, exp_len, exp_ovr);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] p[$];
    p = '{8'h05, 8'h06, 8'h07, 8'h12};
    send_pkt(p, 170, 170);
    repeat (5) @(negedge clk);
    send_byte(8'h33, 0, 1'b0);
    repeat (169) @(negedge clk);
    send_byte(8'h44, 1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    exp_cnt = 0;
    checks++;
    if ({bus.WE, bus.wrAdr, bus.wrData, bus.full, bus.errSum, bus.errLen, bus.errOvr, bus.busy, bus.pktCnt} !== '0) begin
      errors++;
      $display("FAIL reset_mid: WE=%b wrAdr=%0d wrData=%h flags=%b%b%b%b busy=%b pktCnt=%0d, required all 0",
               bus.WE, bus.wrAdr, bus.wrData, bus.full, bus.errSum, bus.errLen, bus.errOvr, bus.busy, bus.pktCnt);
    end
    rst = 1'b0;
    repeat (GAP_CYC + 10) @(negedge clk);
    checks++;
    if (n_full !== exp_full || n_sum !== exp_sum || n_len !== exp_len || n_ovr !== exp_ovr || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_quiet: full/errSum/errLen/errOvr=%0d/%0d/%0d/%0d busy=%b, required %0d/%0d/%0d/%0d busy=0",
               n_full, n_sum, n_len, n_ovr, bus.busy, exp_full, exp_sum, exp_len, exp_ovr);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] p[$];
    logic [7:0] b;
    for (int n = 0; n < 4; n++) begin
      p.delete();
      b = 8'($urandom);
      p.push_back(b);
      p.push_back(8'h00);
      p.push_back(8'h01);
      p.push_back(8'(b + 8'h01));
      send_pkt(p, 170, 170);
    end
    checks++;
    if (bus.pktCnt !== '0) begin
      errors++;
      $display("FAIL wrap: pktCnt=%0d after four good packets from 0, required 0", bus.pktCnt);
    end
  endtask

  task automatic test_random();
    logic [7:0] p[$];
    logic [7:0] b;
    int kind, len, s;
    for (int n = 0; n < 12; n++) begin
      p.delete();
      kind = int'($urandom_range(0, 2));
      len  = (kind == 2) ? int'($urandom_range(1, PKT_LEN - 1)) : int'(PKT_LEN);
      s = 0;
      for (int i = 0; i < len; i++) begin
        b = 8'($urandom);
        if (i == int'(PKT_LEN) - 1) b = (kind == 0) ? 8'(s) : 8'(s + int'($urandom_range(1, 255)));
        else s += int'(b);
        p.push_back(b);
      end
      if (kind != 2) repeat ($urandom_range(0, 2)) p.push_back(8'($urandom));
      send_pkt(p, int'($urandom_range(170, 260)), int'($urandom_range(60, 300)));
    end
    @(negedge clk);
    checks++;
    if (n_full !== exp_full || n_sum !== exp_sum || n_len !== exp_len || n_ovr !== exp_ovr) begin
      errors++;
      $display("FAIL random_totals: full/errSum/errLen/errOvr=%0d/%0d/%0d/%0d, required %0d/%0d/%0d/%0d",
               n_full, n_sum, n_len, n_ovr, exp_full, exp_sum, exp_len, exp_ovr);
    end
  endtask

  initial begin
    test_reset();
    test_good_packet();
    test_bad_checksum();
    test_short_packet();
    test_overrun();
    test_rsttx();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcb_rx_framer.md
Name: lcb_rx_framer

Overview:
Per-channel packet framer between a uartRx byte receiver and its ramUART answer buffer on the LCB side of the M16 orbital link.
- Groups received byte strobes into one fixed-length LCB answer packet.
- Writes the packet bytes to buffer addresses 0..PKT_LEN-1.
- Verifies the trailing checksum byte.
- Issues a one-cycle `full` strobe, which the read arbiter and packers consume; flags length, checksum and overrun errors.
- Five instances, one per UART channel, all on clk80MHz.

Parameters:
- PKT_LEN, 4: bytes per packet, including the checksum byte; legal range 2..32.
- ADDR_W, 5: buffer address width; must satisfy 2^ADDR_W >= PKT_LEN.
- GAP_CYC, 400: idle clk cycles that end a packet. One byte at 4.8 Mbaud is about 167 cycles, so GAP_CYC must be at least 200.
- CNT_W, 16: width of the good-packet counter.

Ports:
- clk, in, 1: clk80MHz.
- rst, in, 1: synchronous, active-high reset.
- rstTx, in, 1: one-cycle pulse when the matching transmitter starts a new request; re-arms the framer.
- strob, in, 1: byte-valid pulse from uartRx; one cycle wide.
- iData, in, 8: received byte; valid while strob=1.
- wrAdr, out, ADDR_W: buffer write address.
- wrData, out, 8: buffer write data.
- WE, out, 1: buffer write enable.
- full, out, 1: one-cycle pulse; a good packet is in the buffer.
- errSum, out, 1: one-cycle pulse; checksum mismatch.
- errLen, out, 1: one-cycle pulse; packet ended by gap before PKT_LEN bytes.
- errOvr, out, 1: one-cycle pulse per surplus byte after a complete packet.
- busy, out, 1: high in RECV, CHECK or TAIL.
- pktCnt, out, CNT_W: count of good packets.

Behaviour:
- Reset (rst=1 at a clock edge, from any state, including mid-packet):
  - state goes to IDLE; byte counter, running sum and gap counter go to 0.
  - All outputs go to 0, including pktCnt.
  - A packet in progress is discarded with no flags.
- States: IDLE, RECV, CHECK, TAIL.
- IDLE:
  - On strob: byte 0 is written, byte count becomes 1, go to RECV.
  - If PKT_LEN=2 is not yet complete it stays in RECV like any other partial packet.
- RECV:
  - Each strob writes the next byte and resets the gap counter to 0.
  - When the PKT_LEN-th byte is accepted, go to CHECK.
  - Without strob the gap counter increments. When it reaches GAP_CYC: errLen pulses on that cycle, state goes to IDLE, no `full`.
- Write timing:
  - A strob sampled at edge t produces WE=1 for exactly the cycle after t.
  - During that cycle wrAdr equals the byte index (0-based) and wrData equals the registered iData.
- Checksum:
  - The running sum is the 8-bit modulo-256 sum of bytes 0..PKT_LEN-2.
  - It is compared in CHECK with byte PKT_LEN-1.
  - All bytes, including the checksum byte, are written to the buffer regardless of the result.
- CHECK (lasts exactly one cycle):
  - The last strob is at edge t; WE for the last byte is high in cycle t+1; full or errSum is high in cycle t+2.
  - On a match: full=1 and pktCnt increments, wrapping from all-ones to 0.
  - On a mismatch: errSum=1.
  - Then go to TAIL.
- TAIL:
  - A strob is not written; errOvr pulses the next cycle and the gap counter resets.
  - After GAP_CYC idle cycles, go to IDLE.
- rstTx=1 in any state:
  - Go to IDLE next cycle; clear counters and sum; no flags.
  - If strob coincides with rstTx, the byte is discarded.
  - rst has priority over rstTx.
- Counter rules:
  - The gap counter saturates and never wraps.
  - The byte counter never exceeds PKT_LEN.
  - wrAdr never exceeds PKT_LEN-1.
- Output exclusivity: full, errSum, errLen and errOvr are never high in the same cycle. WE is never high in the same cycle as full.

Decomposition:
- Shared package lcb_pkg holds:
  - the state encoding (IDLE=0, RECV=1, CHECK=2, TAIL=3);
  - the default constants PKT_LEN_DEF=4, GAP_CYC_DEF=400, LCB_ADDR_W=5;
  - the checksum function `lcb_sum8`.
- One natural sub-module, lcb_gap_timer: a saturating idle counter with clear, enable and a `timeout` output. It is reused by the framer and later by the transmitter watchdog.

Test Plan:
1. Good packet: PKT_LEN=4, bytes 0x10, 0x20, 0x30, 0x60, strobes 170 cycles apart.
   - WE at wrAdr 0,1,2,3 with those data.
   - full=1 exactly 2 cycles after the 4th strob; pktCnt=1; no error flags.
2. Bad checksum: bytes 0x10, 0x20, 0x30, 0x61.
   - All 4 bytes written.
   - errSum=1 at t+2 after the last strob; full stays 0; pktCnt unchanged.
3. Short packet: bytes 0x01, 0x02, then silence.
   - errLen=1 exactly GAP_CYC cycles after the 2nd strob; state IDLE.
   - A next byte 0xAA is written at wrAdr 0.
4. Overrun: good packet plus a 5th byte 0x55 100 cycles later.
   - No WE for 0x55; errOvr=1 on the next cycle.
   - Return to IDLE only after GAP_CYC idle cycles following 0x55.
5. rstTx mid-packet: after 2 bytes, pulse rstTx together with a strob of 0x77.
   - 0x77 is not written; no flags.
   - The next packet 0x01, 0x01, 0x01, 0x03 gives full=1 with writes at addresses 0..3.
6. Reset and wrap:
   - rst asserted mid-packet: all outputs are 0 the next cycle and pktCnt=0.
   - With CNT_W=2, 4 good packets bring pktCnt back to 0.
